// File: rtl/audio_mix_adder.sv
// Pipelined signed audio mixer: a log2(NCH)-stage registered adder tree, then an output register with overflow flag and counter.
// Define AUDIO_MIX_ADDER_SAT_EN to clamp overflowed sums; the default build wraps to the low WIDTH bits.
module audio_mix_adder #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 ovf_clr,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     s,
  output logic                 ovf,
  output logic [15:0]          ovf_cnt
);

  localparam int unsigned LOG = $clog2(NCH);
  localparam int unsigned SW  = WIDTH + LOG;

  if (NCH != 2 && NCH != 4 && NCH != 8) begin : g_bad_nch
    $error("audio_mix_adder: NCH must be 2, 4 or 8");
  end

  // One valid bit per tree stage; bit LOG-1 accompanies the final tree sum.
  logic [LOG-1:0] vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (ce) begin
      vld <= LOG'({vld, in_valid});
    end
  end

  // Stage k holds NCH>>k sums, each one bit wider than its operands, so nothing wraps inside the tree.
  for (genvar k = 1; k <= LOG; k++) begin : g_stage
    localparam int unsigned SWK = WIDTH + k;
    localparam int unsigned NK  = NCH >> k;

    logic signed [SWK-1:0] sum [NK];

    if (k == 1) begin : g_leaf
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < NK; j++) sum[j] <= '0;
        end else if (ce) begin
          for (int j = 0; j < NK; j++) begin
            sum[j] <= SWK'(signed'(din[2*j*WIDTH +: WIDTH]))
                    + SWK'(signed'(din[(2*j+1)*WIDTH +: WIDTH]));
          end
        end
      end
    end else begin : g_node
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < NK; j++) sum[j] <= '0;
        end else if (ce) begin
          for (int j = 0; j < NK; j++) begin
            sum[j] <= SWK'(g_stage[k-1].sum[2*j]) + SWK'(g_stage[k-1].sum[2*j+1]);
          end
        end
      end
    end
  end

  logic signed [SW-1:0] total_c;
  logic                 ovf_c;
  logic [WIDTH-1:0]     s_c;

  assign total_c = g_stage[LOG].sum[0];
  // Out of range exactly when the sum differs from the sign extension of its low WIDTH bits.
  assign ovf_c   = (total_c != SW'(signed'(total_c[WIDTH-1:0])));

`ifdef AUDIO_MIX_ADDER_SAT_EN
  always_comb begin
    s_c = total_c[WIDTH-1:0];
    if (ovf_c) begin
      s_c = total_c[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign s_c = total_c[WIDTH-1:0];
`endif

  // Output register and saturating overflow counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      ovf       <= 1'b0;
      ovf_cnt   <= '0;
    end else if (ce) begin
      out_valid <= vld[LOG-1];
      s         <= s_c;
      ovf       <= vld[LOG-1] & ovf_c;
      if (ovf_clr) begin
        ovf_cnt <= '0;
      end else if (vld[LOG-1] && ovf_c && ovf_cnt != 16'hFFFF) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_audio_mix_adder.sv
// Self-checking bench for audio_mix_adder (WIDTH=31, NCH=4): directed cases plus random traffic against a sample-history model.
// Follows the AUDIO_MIX_ADDER_SAT_EN build choice of the design.
module tb_audio_mix_adder;

  localparam int unsigned WIDTH = 31;
  localparam int unsigned NCH   = 4;
  localparam int unsigned LAT   = 3;
  localparam longint      SMAX  = (longint'(1) << (WIDTH-1)) - 1;
  localparam longint      SMIN  = -(longint'(1) << (WIDTH-1));

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 ce = 1'b0;
  logic                 in_valid = 1'b0;
  logic [NCH*WIDTH-1:0] din = '0;
  logic                 ovf_clr = 1'b0;
  logic                 out_valid;
  logic [WIDTH-1:0]     s;
  logic                 ovf;
  logic [15:0]          ovf_cnt;

  audio_mix_adder #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .din(din),
    .ovf_clr(ovf_clr), .out_valid(out_valid), .s(s), .ovf(ovf), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: history of the inputs taken on ce=1 edges; output after an edge is the entry from LAT-1 ce edges earlier.
  logic   hv[$];
  longint hs[$];
  logic   exp_vld = 1'b0;
  logic   exp_ovf = 1'b0;
  longint exp_sum = 0;
  int     exp_cnt = 0;

  logic   collect = 1'b0;
  longint seen[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint chan(input logic [NCH*WIDTH-1:0] d, input int i);
    longint x;
    x = longint'(d[i*WIDTH +: WIDTH]);
    if (x > SMAX) x = x - (longint'(1) << WIDTH);
    return x;
  endfunction

  function automatic longint mix(input logic [NCH*WIDTH-1:0] d);
    longint t = 0;
    for (int i = 0; i < NCH; i++) t += chan(d, i);
    return t;
  endfunction

  function automatic logic [NCH*WIDTH-1:0] pack(input longint c0, input longint c1,
                                                input longint c2, input longint c3);
    logic [NCH*WIDTH-1:0] d;
    d[0*WIDTH +: WIDTH] = WIDTH'(c0);
    d[1*WIDTH +: WIDTH] = WIDTH'(c1);
    d[2*WIDTH +: WIDTH] = WIDTH'(c2);
    d[3*WIDTH +: WIDTH] = WIDTH'(c3);
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] model_s(input longint t);
`ifdef AUDIO_MIX_ADDER_SAT_EN
    if (t > SMAX) return WIDTH'(SMAX);
    if (t < SMIN) return WIDTH'(SMIN);
`endif
    return WIDTH'(t);
  endfunction

  task automatic model_reset();
    hv = {};
    hs = {};
    for (int i = 0; i < LAT-1; i++) begin
      hv.push_back(1'b0);
      hs.push_back(0);
    end
    exp_vld = 1'b0;
    exp_ovf = 1'b0;
    exp_sum = 0;
    exp_cnt = 0;
  endtask

  task automatic model_edge(input logic r, input logic c, input logic v,
                            input logic [NCH*WIDTH-1:0] d, input logic cl);
    if (r) begin
      model_reset();
    end else if (c) begin
      hv.push_back(v);
      hs.push_back(mix(d));
      exp_vld = hv.pop_front();
      exp_sum = hs.pop_front();
      exp_ovf = exp_vld && (exp_sum > SMAX || exp_sum < SMIN);
      if (cl) exp_cnt = 0;
      else if (exp_ovf && exp_cnt < 65535) exp_cnt++;
    end
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, compare 1 time unit later.
  task automatic step(input logic r, input logic c, input logic v,
                      input logic [NCH*WIDTH-1:0] d, input logic cl);
    @(negedge clk);
    rst = r; ce = c; in_valid = v; din = d; ovf_clr = cl;
    @(posedge clk);
    model_edge(r, c, v, d, cl);
    #1;
    check("out_valid", 64'(out_valid), 64'(exp_vld));
    check("ovf", 64'(ovf), 64'(exp_ovf));
    check("ovf_cnt", 64'(ovf_cnt), 64'(exp_cnt));
    if (exp_vld) check("s", 64'(s), 64'(model_s(exp_sum)));
    if (collect && c && out_valid) seen.push_back(chan({{(NCH-1)*WIDTH{1'b0}}, s}, 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [NCH*WIDTH-1:0] rnd_din();
    logic [NCH*WIDTH-1:0] d;
    for (int i = 0; i < NCH; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return d;
  endfunction

  logic [NCH*WIDTH-1:0] pos_all;
  logic [NCH*WIDTH-1:0] neg_all;

  initial begin
    model_reset();
    pos_all = pack(64'h3FFF_FFFF, 64'h3FFF_FFFF, 64'h3FFF_FFFF, 64'h3FFF_FFFF);
    neg_all = pack(64'h4000_0000, 64'h4000_0000, 64'h4000_0000, 64'h4000_0000);

    // Reset held with valid traffic, then quiet release.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, rnd_din(), 1'b0);
      check("rst_s", 64'(s), 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      check("rst_rel_s", 64'(s), 64'd0);
    end

    // Basic mix {1,2,3,-7} -> -1.
    step(1'b0, 1'b1, 1'b1, pack(1, 2, 3, -7), 1'b0);
    idle(2);
    check("basic_s", 64'(s), 64'h7FFF_FFFF);
    check("basic_vld", 64'(out_valid), 64'd1);
    idle(1);
    check("basic_one_pulse", 64'(out_valid), 64'd0);

    // Positive overflow.
    step(1'b0, 1'b1, 1'b1, pos_all, 1'b0);
    idle(2);
    check("pos_ovf", 64'(ovf), 64'd1);
    check("pos_cnt", 64'(ovf_cnt), 64'd1);
`ifdef AUDIO_MIX_ADDER_SAT_EN
    check("pos_s", 64'(s), 64'h3FFF_FFFF);
`else
    check("pos_s", 64'(s), 64'h7FFF_FFFC);
`endif

    // Negative overflow.
    step(1'b0, 1'b1, 1'b1, neg_all, 1'b0);
    idle(2);
    check("neg_ovf", 64'(ovf), 64'd1);
`ifdef AUDIO_MIX_ADDER_SAT_EN
    check("neg_s", 64'(s), 64'h4000_0000);
`else
    check("neg_s", 64'(s), 64'h0000_0000);
`endif
    idle(2);

    // Stall with valid-looking garbage presented while ce=0.
    collect = 1'b1;
    step(1'b0, 1'b1, 1'b1, pack(10, 0, 0, 0), 1'b0);
    step(1'b0, 1'b1, 1'b1, pack(0, 20, 0, 0), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, rnd_din(), 1'b1);
    step(1'b0, 1'b1, 1'b1, pack(5, 5, 10, 10), 1'b0);
    idle(4);
    collect = 1'b0;
    check("stall_count", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      check("stall_s0", 64'(seen[0]), 64'd10);
      check("stall_s1", 64'(seen[1]), 64'd20);
      check("stall_s2", 64'(seen[2]), 64'd30);
    end

    // Reset mid-stream drops in-flight samples.
    step(1'b0, 1'b1, 1'b1, pack(1, 1, 1, 1), 1'b0);
    step(1'b0, 1'b1, 1'b1, pack(2, 2, 2, 2), 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle(4);

    // Random traffic with stalls, clears and occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
           1'($urandom), rnd_din(), ($urandom_range(0, 99) < 5));
    end

    // Counter saturation, then clear coincident with an overflowed output.
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 1'b1, pos_all, 1'b0);
    idle(2);
    check("cnt_sat", 64'(ovf_cnt), 64'hFFFF);
    step(1'b0, 1'b1, 1'b1, pos_all, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    check("clr_ovf", 64'(ovf), 64'd1);
    check("clr_cnt", 64'(ovf_cnt), 64'd0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_mix_adder.md
AUDIO_MIX_ADDER -- requirements
Module: audio_mix_adder

Interface
REQ-001 Parameter WIDTH, default 31, sample width in bits, signed two's complement.
REQ-002 Parameter NCH, default 4, input channel count; legal values 2, 4, 8; other values SHALL fail elaboration.
REQ-003 Derived constant L = log2(NCH)+1, pipeline latency in cycles.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ce  input  1  clock enable; when 0, all pipeline state holds.
REQ-007 in_valid  input  1  din carries a valid sample set this cycle.
REQ-008 din  input  NCH*WIDTH  packed channels, channel 0 in bits [WIDTH-1:0].
REQ-009 ovf_clr  input  1  clears ovf_cnt.
REQ-010 out_valid  output  1  s and ovf carry a valid result.
REQ-011 s  output  WIDTH  mixed sum.
REQ-012 ovf  output  1  range overflow flag for the sample on s.
REQ-013 ovf_cnt  output  16  count of overflowed output samples.

Function
REQ-014 Adder tree SHALL have log2(NCH) registered pairwise-add stages; stage k operands are WIDTH+k-1 bits, sign-extended, and results are WIDTH+k bits, so no internal wrap.
REQ-015 An output register SHALL follow the tree; an input sampled with ce=1 appears on s exactly L ce=1 cycles later.
REQ-016 A valid bit SHALL travel with each stage; out_valid = in_valid delayed by L ce=1 cycles.
REQ-017 ce=0 SHALL freeze data, valid bits, s, ovf, out_valid and ovf_cnt; no sample is dropped or duplicated across a stall.
REQ-018 Data registers MAY load on invalid cycles; ovf SHALL be 0 whenever out_valid is 0.
REQ-019 ovf=1 when the full-precision sum lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 ovf_cnt SHALL increment by 1 on each ce=1 cycle that registers a valid overflowed sample, and saturate at 0xFFFF.
REQ-021 ovf_clr=1 with ce=1 SHALL set ovf_cnt to 0 and takes priority over a simultaneous increment; ovf_clr with ce=0 is ignored.
REQ-022 Back-to-back valid inputs SHALL be accepted every ce=1 cycle; throughput is one sample set per cycle.

Reset
REQ-023 rst=1 SHALL clear all pipeline valid bits, out_valid, s, ovf and ovf_cnt to 0 on the next rising edge, regardless of ce.
REQ-024 Reset mid-stream SHALL discard all in-flight samples; no out_valid pulse from pre-reset inputs follows reset release.
REQ-025 Data registers internal to the tree SHALL be cleared to 0 on reset.

Configuration
REQ-026 Macro AUDIO_MIX_ADDER_SAT_EN defined: on overflow, s SHALL clamp to 2^(WIDTH-1)-1 for positive sums or -2^(WIDTH-1) for negative sums.
REQ-027 Macro AUDIO_MIX_ADDER_SAT_EN undefined: s SHALL be the low WIDTH bits of the full-precision sum (wrap); ovf and ovf_cnt behave identically in both builds.

Verification (WIDTH=31, NCH=4, L=3)
REQ-028 Reset: rst=1 for 2 cycles with in_valid=1, ce=1 -> out_valid=0, s=0, ovf=0, ovf_cnt=0 throughout and for 3 cycles after release if in_valid=0.
REQ-029 Basic: din channels {1,2,3,-7} valid, ce=1 -> 3 cycles later s=-1 (0x7FFFFFFF), out_valid=1 for exactly one cycle, ovf=0.
REQ-030 Positive overflow: all channels 0x3FFFFFFF -> ovf=1, ovf_cnt=1; SAT build s=0x3FFFFFFF; wrap build s=0x7FFFFFFC.
REQ-031 Negative overflow: all channels 0x40000000 (-2^30) -> ovf=1; SAT build s=0x40000000; wrap build s=0x00000000.
REQ-032 Stall: valid samples with sums 10, 20, 30 on consecutive cycles, ce=0 for 5 cycles after the second -> outputs held during stall; s sequence 10, 20, 30 with no gaps in valid outputs beyond the stall.
REQ-033 Counter: 65540 consecutive overflowed samples -> ovf_cnt=0xFFFF; then ovf_clr=1 coincident with an overflowed output -> ovf_cnt=0.
